// File: rtl/mux4_arb_pkg.sv
// Shared types and helpers for the 4-way round-robin bus arbiter.
//   state_t  : arbiter FSM state (IDLE / GRANT)
//   NREQ     : number of requesters (4)
//   IDX_W    : requester index width (2)
//   rr_pick  : round-robin search -> {found, idx}
package mux4_arb_pkg;

  localparam int NREQ  = 4;
  localparam int IDX_W = 2;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  // Search order is p+1, p+2, p+3, p (mod 4). Returns {found, idx}.
  function automatic logic [IDX_W:0] rr_pick(input logic [NREQ-1:0]  r,
                                             input logic [IDX_W-1:0] p);
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = p + IDX_W'(i);
      if (!found && r[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/mux4_bus.sv
// WIDTH-bit 4:1 bus mux built from per-bit mux4 cells.
//   mux4     : single-bit 4:1 mux cell (d[3:0], s[1:0] -> y)
//   mux4_bus : din0..din3 [WIDTH], sel [2] -> dout [WIDTH]
module mux4 (
  input  logic [3:0] d,
  input  logic [1:0] s,
  output logic       y
);
  assign y = d[s];
endmodule

module mux4_bus #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic [WIDTH-1:0] din3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] dout
);
  genvar b;
  generate
    for (b = 0; b < WIDTH; b++) begin : g_bit
      mux4 u_cell (
        .d ({din3[b], din2[b], din1[b], din0[b]}),
        .s (sel),
        .y (dout[b])
      );
    end
  endgenerate
endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter in front of a shared WIDTH-bit 4:1 bus mux.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req[3:0]          per-requester request, held while data is available
//   din0..din3        requester data
//   out_ready         downstream accepts dout
//   gnt[3:0]          registered one-hot grant (0 = none)
//   sel[1:0]          registered mux select, index of the gnt bit
//   out_valid         dout valid (granted and requester still asserting)
//   dout              din[sel]
//   busy              FSM in GRANT
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic [WIDTH-1:0] din3,
  input  logic             out_ready,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] dout,
  output logic             busy
);

  localparam int             HW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0]  HOLD_LAST = HW'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [HW-1:0]    hold_q, hold_d;

  logic             xfer;
  logic [NREQ-1:0]  others;
  logic [IDX_W:0]   pick;
  logic             release_now;

  assign out_valid = (state_q == GRANT) & req[sel_q];
  assign xfer      = out_valid & out_ready;
  // In IDLE gnt_q is zero, so this is simply req; in GRANT it excludes the owner.
  assign others    = req & ~gnt_q;
  assign pick      = rr_pick(others, ptr_q);
  // Tenure only expires on a completed beat, so sel cannot move under backpressure.
  assign release_now = ~req[sel_q] | (xfer & (hold_q == HOLD_LAST) & (|others));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= IDX_W'(NREQ - 1);
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (pick[IDX_W]) begin
          state_d = GRANT;
          gnt_d   = NREQ'(1) << pick[IDX_W-1:0];
          sel_d   = pick[IDX_W-1:0];
          ptr_d   = pick[IDX_W-1:0];
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          if (pick[IDX_W]) begin
            // Direct handover, no idle bubble.
            gnt_d  = NREQ'(1) << pick[IDX_W-1:0];
            sel_d  = pick[IDX_W-1:0];
            ptr_d  = pick[IDX_W-1:0];
            hold_d = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (xfer && hold_q != HOLD_LAST) begin
          // Saturates at HOLD_LAST when uncontended; tenure continues.
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = (state_q == GRANT);

  mux4_bus #(.WIDTH(WIDTH)) u_bus (
    .din0 (din0),
    .din1 (din1),
    .din2 (din2),
    .din3 (din3),
    .sel  (sel_q),
    .dout (dout)
  );

endmodule
